// File: rtl/aesl_dl_pkg.sv
// Shared helpers for the simulation-only deadlock detector: width helper and
// the legal ceiling for stall thresholds.
package aesl_dl_pkg;

  localparam int STALL_THRESH_MAX = 65535;

  function automatic int popcount_w(int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/aesl_stall_chan_cnt.sv
// One channel of the stall qualifier: a saturating run-length counter whose
// value doubles as CLEAR / COUNTING / BLOCKED state.
module aesl_stall_chan_cnt #(
  parameter int STALL_THRESH = 16,
  parameter int CNT_W        = $clog2(STALL_THRESH + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic freeze,
  output logic blocked,
  output logic blocked_nxt,
  output logic rise
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(STALL_THRESH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blocked_q, blocked_d;

  // Any low sample restarts the run; a full run saturates at the threshold.
  always_comb begin
    cnt_d = cnt_q;
    if (!freeze) begin
      if (!raw) begin
        cnt_d = '0;
      end else if (cnt_q != THRESH_C) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    blocked_d = (cnt_d == THRESH_C);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      blocked_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      blocked_q <= blocked_d;
    end
  end

  assign blocked     = blocked_q;
  assign blocked_nxt = blocked_d;
  // While frozen cnt_d equals cnt_q, so no rise can be reported.
  assign rise        = blocked_d & ~blocked_q;

endmodule

// File: rtl/aesl_stall_filter_unit.sv
// Per-process stall qualifier: filters raw blocked terms through per-channel
// run-length counters and freezes the whole graph during a deadlock report.
module aesl_stall_filter_unit
  import aesl_dl_pkg::*;
#(
  parameter int CHAN_NUM     = 1,
  parameter int STALL_THRESH = 16,
  parameter int CNT_W        = $clog2(STALL_THRESH + 1)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [CHAN_NUM-1:0]               raw_dep_vec,
  input  logic                              dl_detect_in,
  output logic [CHAN_NUM-1:0]               proc_dep_vld_vec,
  output logic                              stall_event,
  output logic [popcount_w(CHAN_NUM)-1:0]   blocked_cnt
);

  localparam int BC_W = popcount_w(CHAN_NUM);

  if (STALL_THRESH < 1 || STALL_THRESH > STALL_THRESH_MAX) begin : g_bad_thresh
    $error("aesl_stall_filter_unit: STALL_THRESH out of range 1..65535");
  end

  logic [CHAN_NUM-1:0] vld_d;
  logic [CHAN_NUM-1:0] rise_vec;
  logic                stall_event_q, stall_event_d;
  logic [BC_W-1:0]     blocked_cnt_q, blocked_cnt_d;

  genvar gi;
  for (gi = 0; gi < CHAN_NUM; gi++) begin : g_chan
    aesl_stall_chan_cnt #(
      .STALL_THRESH (STALL_THRESH),
      .CNT_W        (CNT_W)
    ) u_cnt (
      .clock       (clock),
      .reset       (reset),
      .raw         (raw_dep_vec[gi]),
      .freeze      (dl_detect_in),
      .blocked     (proc_dep_vld_vec[gi]),
      .blocked_nxt (vld_d[gi]),
      .rise        (rise_vec[gi])
    );
  end

  // Popcount of the next-state vector keeps blocked_cnt aligned with the vector.
  always_comb begin
    stall_event_d = ~dl_detect_in & (|rise_vec);
    blocked_cnt_d = '0;
    for (int i = 0; i < CHAN_NUM; i++) begin
      blocked_cnt_d = blocked_cnt_d + BC_W'(vld_d[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_event_q <= 1'b0;
      blocked_cnt_q <= '0;
    end else begin
      stall_event_q <= stall_event_d;
      blocked_cnt_q <= blocked_cnt_d;
    end
  end

  assign stall_event = stall_event_q;
  assign blocked_cnt = blocked_cnt_q;

endmodule
